// File: rtl/sme_pkg.sv
// -----------------------------------------------------------------------------
// sme_pkg
// Shared definitions for the parametrised string-match engine (sme_param):
//   - state_e      : FSM states of the top level
//   - CH_*         : metacharacter and separator codes
//   - to_lower()   : ASCII upper-to-lower fold, used only when the engine is
//                    built with SME_CASE_FOLD_EN defined
// -----------------------------------------------------------------------------
package sme_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_STR,
    LOAD_PAT,
    SCAN,
    STAR_SCAN,
    DONE
  } state_e;

  localparam logic [7:0] CH_CARET  = 8'h5E;  // '^' start of string / word
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$' end of string / word
  localparam logic [7:0] CH_DOT    = 8'h2E;  // '.' any single character
  localparam logic [7:0] CH_STAR   = 8'h2A;  // '*' zero or more characters
  localparam logic [7:0] CH_SPACE  = 8'h20;  // word separator and buffer fill

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/sme_char_cmp.sv
// -----------------------------------------------------------------------------
// sme_char_cmp
// Combinational single-element matcher: decides whether one pattern element
// is satisfied at the current string position. All metacharacter semantics
// and the optional case fold live here; the caller handles '*' itself and
// decides how far the string pointer advances.
//
// Build option: SME_CASE_FOLD_EN -- when defined, literal compares fold ASCII
// 'A'-'Z' to 'a'-'z' on both operands (requires CHAR_W >= 8).
//
// Ports:
//   str_char_i  string character at the current position
//   pat_char_i  current pattern element
//   at_start_i  current position is string index 0
//   at_end_i    current position is one past the last string character
//   hit_o       element is satisfied
// -----------------------------------------------------------------------------
module sme_char_cmp
  import sme_pkg::*;
#(
  parameter int CHAR_W = 8
) (
  input  logic [CHAR_W-1:0] str_char_i,
  input  logic [CHAR_W-1:0] pat_char_i,
  input  logic              at_start_i,
  input  logic              at_end_i,
  output logic              hit_o
);

  logic              is_space;
  logic [CHAR_W-1:0] s_lit;
  logic [CHAR_W-1:0] p_lit;

  assign is_space = (str_char_i == CHAR_W'(CH_SPACE));

`ifdef SME_CASE_FOLD_EN
  always_comb begin
    s_lit      = str_char_i;
    p_lit      = pat_char_i;
    s_lit[7:0] = to_lower(str_char_i[7:0]);
    p_lit[7:0] = to_lower(pat_char_i[7:0]);
  end
`else
  assign s_lit = str_char_i;
  assign p_lit = pat_char_i;
`endif

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here via the leading default) so no latch is inferred.
  always_comb begin
    hit_o = 1'b0;
    if (pat_char_i == CHAR_W'(CH_CARET)) begin
      // Start of string, or a space that is consumed so the next element
      // lines up with the first character of the word.
      hit_o = at_start_i || (!at_end_i && is_space);
    end else if (pat_char_i == CHAR_W'(CH_DOLLAR)) begin
      hit_o = at_end_i || is_space;
    end else if (pat_char_i == CHAR_W'(CH_DOT)) begin
      hit_o = !at_end_i;
    end else begin
      // A '*' reaching this point is a second star and compares literally.
      hit_o = !at_end_i && (s_lit == p_lit);
    end
  end

endmodule

// File: rtl/sme_param.sv
// -----------------------------------------------------------------------------
// sme_param
// Parametrised string-match engine. A string is loaded byte-serially, then
// one or more patterns; each pattern is searched in the retained string and
// the leftmost match start is reported with a one-cycle valid strobe.
//
// Build option: SME_CASE_FOLD_EN (see sme_char_cmp) enables case-insensitive
// literal compares.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   chardata     input character, qualified by isstring / ispattern
//   isstring     chardata is the next string character (wins over ispattern)
//   ispattern    chardata is the next pattern character
//   busy         search in progress; inputs ignored
//   valid        one-cycle result strobe
//   match        pattern found (held until the next valid)
//   match_index  start of the leftmost match, 0 when no match
// -----------------------------------------------------------------------------
module sme_param
  import sme_pkg::*;
#(
  parameter int MAX_STR_LEN = 32,
  parameter int MAX_PAT_LEN = 8,
  parameter int CHAR_W      = 8,
  parameter int IDX_W       = $clog2(MAX_STR_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index
);

  localparam int               PI_W    = $clog2(MAX_PAT_LEN + 1);
  localparam logic [IDX_W-1:0] STR_MAX = IDX_W'(MAX_STR_LEN);
  localparam logic [PI_W-1:0]  PAT_MAX = PI_W'(MAX_PAT_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [PI_W-1:0]  PI_ONE  = PI_W'(1);

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] str_len_q,   str_len_d;
  logic [PI_W-1:0]  pat_len_q,   pat_len_d;
  logic [IDX_W-1:0] st_q,        st_d;       // start position of this attempt
  logic [IDX_W-1:0] si_q,        si_d;       // string compare pointer
  logic [PI_W-1:0]  pi_q,        pi_d;       // pattern compare pointer
  logic [IDX_W-1:0] star_si_q,   star_si_d;  // string position the star span ends at
  logic [PI_W-1:0]  star_pi_q,   star_pi_d;  // pattern index of the star
  logic [IDX_W-1:0] cand_q,      cand_d;     // match_index if this attempt succeeds
  logic             lead_q,      lead_d;     // still inside the leading '^' run
  logic             match_q,     match_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;

  // Both buffers carry one entry beyond the maximum so the pointer widths
  // index them exactly; the extra string entry always holds a space and is
  // what the comparator sees at the end of a full string.
  logic [CHAR_W-1:0] str_q [MAX_STR_LEN+1];
  logic [CHAR_W-1:0] pat_q [MAX_PAT_LEN+1];

  logic              str_in, pat_in;
  logic              str_first, str_app, pat_first, pat_app;
  logic [CHAR_W-1:0] cur_s, cur_p;
  logic              at_start, at_end, p_last;
  logic              is_star, is_caret, is_space;
  logic              hit, consume;

  assign str_in   = isstring;
  assign pat_in   = ispattern & ~isstring;

  assign cur_s    = str_q[si_q];
  assign cur_p    = pat_q[pi_q];
  assign at_start = (si_q == '0);
  assign at_end   = (si_q == str_len_q);
  assign p_last   = (pi_q == (pat_len_q - PI_ONE));
  assign is_star  = (cur_p == CHAR_W'(CH_STAR));
  assign is_caret = (cur_p == CHAR_W'(CH_CARET));
  assign is_space = (cur_s == CHAR_W'(CH_SPACE));

  // Every hit consumes one character except '^' matched at string start and
  // '$' matched at string end, which are zero-width.
  assign consume  = !at_end && (!is_caret || is_space);

  sme_char_cmp #(
    .CHAR_W (CHAR_W)
  ) u_char_cmp (
    .str_char_i (cur_s),
    .pat_char_i (cur_p),
    .at_start_i (at_start),
    .at_end_i   (at_end),
    .hit_o      (hit)
  );

  always_comb begin
    state_d     = state_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    st_d        = st_q;
    si_d        = si_q;
    pi_d        = pi_q;
    star_si_d   = star_si_q;
    star_pi_d   = star_pi_q;
    cand_d      = cand_q;
    lead_d      = lead_q;
    match_d     = match_q;
    match_idx_d = match_idx_q;
    str_first   = 1'b0;
    str_app     = 1'b0;
    pat_first   = 1'b0;
    pat_app     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (str_in) begin
          str_first = 1'b1;
          str_len_d = IDX_ONE;
          state_d   = LOAD_STR;
        end else if (pat_in) begin
          pat_first = 1'b1;
          pat_len_d = PI_ONE;
          state_d   = LOAD_PAT;
        end
      end

      LOAD_STR: begin
        if (str_in) begin
          if (str_len_q < STR_MAX) begin
            str_app   = 1'b1;
            str_len_d = str_len_q + IDX_ONE;
          end
        end else if (pat_in) begin
          pat_first = 1'b1;
          pat_len_d = PI_ONE;
          state_d   = LOAD_PAT;
        end else begin
          // A gap ends the string; it stays stored for later patterns.
          state_d = IDLE;
        end
      end

      LOAD_PAT: begin
        if (pat_in) begin
          if (pat_len_q < PAT_MAX) begin
            pat_app   = 1'b1;
            pat_len_d = pat_len_q + PI_ONE;
          end
        end else begin
          // End of the pattern burst (a string character here is ignored).
          st_d    = '0;
          si_d    = '0;
          pi_d    = '0;
          cand_d  = '0;
          lead_d  = 1'b1;
          state_d = SCAN;
        end
      end

      SCAN, STAR_SCAN: begin
        if ((state_q == SCAN) && is_star) begin
          // First star: remember where it sits and start with an empty span.
          star_pi_d = pi_q;
          star_si_d = si_q;
          lead_d    = 1'b0;
          if (p_last) begin
            match_d     = 1'b1;
            match_idx_d = cand_q;
            state_d     = DONE;
          end else begin
            pi_d    = pi_q + PI_ONE;
            state_d = STAR_SCAN;
          end
        end else if (hit) begin
          if (consume) begin
            si_d = si_q + IDX_ONE;
          end
          if (lead_q) begin
            if (is_caret) begin
              if (consume) begin
                cand_d = si_q + IDX_ONE;
              end
            end else begin
              lead_d = 1'b0;
            end
          end
          if (p_last) begin
            match_d     = 1'b1;
            match_idx_d = cand_d;
            state_d     = DONE;
          end else begin
            pi_d = pi_q + PI_ONE;
          end
        end else if (state_q == SCAN) begin
          // Mismatch before any star: retry from the next start position,
          // without spending an extra cycle on the restart.
          if (st_q == str_len_q) begin
            match_d     = 1'b0;
            match_idx_d = '0;
            state_d     = DONE;
          end else begin
            st_d   = st_q + IDX_ONE;
            si_d   = st_q + IDX_ONE;
            cand_d = st_q + IDX_ONE;
            pi_d   = '0;
            lead_d = 1'b1;
          end
        end else begin
          // Mismatch after the star: grow the star span by one character.
          // Once the span has swallowed the whole string the search fails;
          // later start positions only see a subset of the same suffix tries.
          if (star_si_q == str_len_q) begin
            match_d     = 1'b0;
            match_idx_d = '0;
            state_d     = DONE;
          end else begin
            star_si_d = star_si_q + IDX_ONE;
            si_d      = star_si_q + IDX_ONE;
            pi_d      = star_pi_q + PI_ONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      st_q        <= '0;
      si_q        <= '0;
      pi_q        <= '0;
      star_si_q   <= '0;
      star_pi_q   <= '0;
      cand_q      <= '0;
      lead_q      <= 1'b0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      st_q        <= st_d;
      si_q        <= si_d;
      pi_q        <= pi_d;
      star_si_q   <= star_si_d;
      star_pi_q   <= star_pi_d;
      cand_q      <= cand_d;
      lead_q      <= lead_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
    end
  end

  // NOTE: the string buffer is reset because its space fill is architectural
  // (it is what the comparator sees past the end); the pattern buffer is not,
  // since only entries below pat_len, all written first, are ever read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= MAX_STR_LEN; i++) begin
        str_q[i] <= CHAR_W'(CH_SPACE);
      end
    end else if (str_first) begin
      for (int i = 1; i <= MAX_STR_LEN; i++) begin
        str_q[i] <= CHAR_W'(CH_SPACE);
      end
      str_q[0] <= chardata;
    end else if (str_app) begin
      str_q[str_len_q] <= chardata;
    end
  end

  always_ff @(posedge clk) begin
    if (pat_first) begin
      pat_q[0] <= chardata;
    end else if (pat_app) begin
      pat_q[pat_len_q] <= chardata;
    end
  end

  assign busy        = (state_q == SCAN) || (state_q == STAR_SCAN);
  assign valid       = (state_q == DONE);
  assign match       = match_q;
  assign match_index = match_idx_q;

endmodule

// File: doc/sme_param.md
Name: sme_param

Overview:
- Parametrised string-match engine, the next generation of the single-channel SME.
- Loads one string and then one or more patterns over a byte-serial stream.
- For each pattern it searches the stored string and reports whether the pattern matches and, if so, the leftmost start index.
- Adds parametrised depths and widths, a busy indication, pattern reuse against a retained string, a defined overflow policy and an optional case-fold mode.

Parameters:
- MAX_STR_LEN, 32: maximum stored string characters.
- MAX_PAT_LEN, 8: maximum stored pattern characters.
- CHAR_W, 8: character width in bits.
- IDX_W, $clog2(MAX_STR_LEN+1): width of match_index.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- chardata  in  CHAR_W  input character, qualified by isstring/ispattern.
- isstring  in  1  chardata is the next string character.
- ispattern  in  1  chardata is the next pattern character.
- busy  out  1  search in progress; inputs are ignored while high.
- valid  out  1  one-cycle result strobe.
- match  out  1  pattern found; qualified by valid.
- match_index  out  IDX_W  0-based start index of the leftmost match; qualified by valid and match.

Behaviour:
- Reset (synchronous, active-high): FSM goes to IDLE; busy, valid, match, match_index = 0; str_len = pat_len = 0; string buffer filled with 0x20.
- Reset mid-search aborts the search; no valid is produced.
- FSM states: IDLE, LOAD_STR, LOAD_PAT, SCAN, STAR_SCAN, DONE.
- String load:
  - The first isstring cycle after IDLE or DONE clears the buffer and stores char 0.
  - Each later isstring cycle appends one character.
  - Past MAX_STR_LEN, characters are dropped and str_len saturates.
- Pattern load:
  - ispattern cycles append to the pattern buffer; past MAX_PAT_LEN, characters are dropped.
  - A pattern burst may follow DONE directly; the previously stored string is reused.
- Input priority: if isstring and ispattern are both high, isstring wins and the pattern bit is ignored.
- Search start: the first cycle with ispattern low after LOAD_PAT enters SCAN and raises busy.
- Pattern metacharacters:
  - '^' (0x5E): matches string start or the position after a 0x20.
  - '$' (0x24): matches string end or a 0x20; it consumes nothing at string end.
  - '.' (0x2E): matches any single character.
  - '*' (0x2A): matches zero or more characters. At most one '*' per pattern; a second '*' is treated as a literal.
  - Any other character: exact compare.
- Search order: start positions 0..str_len are tried in ascending order; the first success wins.
- Star handling:
  - On '*', SCAN saves the star resume point and moves to STAR_SCAN.
  - On a mismatch after the star, the star span extends by one character and comparison restarts from pattern index star+1.
  - An exhausted string means failure.
- Index rules:
  - match_index is the string position consumed by the first non-'^' pattern element.
  - For '^' after a space, that is the character after the space.
  - For "$" alone, it is str_len.
- Throughput: one character compare per cycle.
- Latency: valid asserts within MAX_STR_LEN*(MAX_PAT_LEN+1)+4 cycles of search start.
- DONE:
  - valid = 1 for exactly one cycle, together with match and match_index.
  - busy drops in the same cycle.
  - match and match_index hold until the next valid.
  - On no match, match = 0 and match_index = 0.
- After DONE: the FSM returns to IDLE. A string or pattern burst may begin the cycle after valid.

Optional Feature:
- Macro SME_CASE_FOLD_EN.
- Defined: literal compares fold ASCII 'A'-'Z' to 'a'-'z' on both operands before comparison; metacharacters are unaffected.
- Undefined: exact binary compare. No extra logic or ports either way.

Decomposition:
- Package sme_pkg:
  - state enum;
  - metacharacter constants CH_CARET, CH_DOLLAR, CH_DOT, CH_STAR, CH_SPACE;
  - function to_lower (used under SME_CASE_FOLD_EN).
- Sub-module sme_char_cmp:
  - combinational single-element matcher;
  - inputs: string char, pattern char, at_start, at_end flags;
  - output: hit. It contains all metacharacter and case-fold logic.
- Top level keeps the buffers, pointers and FSM.

Test Plan:
- String "hello world", pattern "wor" -> valid once; match=1, match_index=6.
- String "the cat sat", pattern "^sat" -> match=1, index 8. Then pattern "^at" (string reused) -> match=0, index 0.
- String "abcde", pattern "b*e" -> match=1, index 1. Then pattern "c*b" -> match=0. Then pattern "de$" -> match=1, index 3.
- String of 40 chars 'x' with MAX_STR_LEN=32, pattern "x$" -> match=1, index 31; the extra characters are dropped.
- Reset asserted while busy, then string "ab", pattern "." -> no valid from the aborted search; the new search gives match=1, index 0.
- String "HeLLo", pattern "ll": with SME_CASE_FOLD_EN -> match=1, index 2; without it -> match=0.
